// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: byte/half/word loads and stores against
// an internal word-organised RAM, the MEM/WB register, and the writeback mux.
module mem_stage #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_m,
  input  logic        regwrite_m,
  input  logic [1:0]  result_src_m,
  input  logic        memwrite_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] writedata_m,
  input  logic [31:0] pc_plus_4_m,
  input  logic [4:0]  rd_m,
  output logic        misaligned_m,
  output logic        mem_wb_regwrite,
  output logic [1:0]  mem_wb_result_src,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_read_data,
  output logic [31:0] mem_wb_pc_plus_4,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] result_w
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  // Byte-lane organised storage so stores only touch enabled lanes.
  logic [NUM_LANES-1:0][7:0] ram [DEPTH_WORDS];

  logic [ADDR_W-1:0]         idx;
  logic [1:0]                lane;
  logic                      is_load;
  logic                      we;
  logic [NUM_LANES-1:0]      byte_en;
  logic [NUM_LANES-1:0][7:0] wdata;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic [7:0]                rd_byte;
  logic [15:0]               rd_half;
  logic [31:0]               load_data;

  // Upper address bits drop out here, so accesses wrap around the RAM.
  assign idx     = alu_result_m[ADDR_W+1:2];
  assign lane    = alu_result_m[1:0];
  assign is_load = (result_src_m == RES_MEM);

  // Alignment is only meaningful when the instruction actually touches memory.
  always_comb begin
    misaligned_m = 1'b0;
    if (memwrite_m || is_load) begin
      case (funct3_m)
        3'b001, 3'b101: misaligned_m = lane[0];
        3'b010:         misaligned_m = (lane != 2'b00);
        default:        misaligned_m = 1'b0;
      endcase
    end
  end

  // Store lane enables and data replicated across lanes so any lane can pick it up.
  always_comb begin
    byte_en = '0;
    wdata   = writedata_m;
    case (funct3_m)
      3'b000: begin
        byte_en = 4'b0001 << lane;
        wdata   = {NUM_LANES{writedata_m[7:0]}};
      end
      3'b001: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{writedata_m[15:0]}};
      end
      3'b010:  byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
  end

  assign we = memwrite_m && !stall_m && !reset && !misaligned_m;

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byte_en[i]) ram[idx][i] <= wdata[i];
      end
    end
  end

  // Combinational read sees pre-edge contents, so a same-cycle store is not visible.
  assign rd_word = ram[idx];
  assign rd_byte = rd_word[lane];
  assign rd_half = lane[1] ? rd_word[3:2] : rd_word[1:0];

  // Select and extend load data; anything that is not a legal aligned load reads as 0.
  always_comb begin
    load_data = '0;
    if (is_load && !misaligned_m) begin
      case (funct3_m)
        3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
        3'b010:  load_data = rd_word;
        3'b100:  load_data = {24'b0, rd_byte};
        3'b101:  load_data = {16'b0, rd_half};
        default: load_data = '0;
      endcase
    end
  end

  // MEM/WB register: reset beats stall, stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_regwrite   <= 1'b0;
      mem_wb_result_src <= 2'b00;
      mem_wb_alu_result <= '0;
      mem_wb_read_data  <= '0;
      mem_wb_pc_plus_4  <= '0;
      mem_wb_rd         <= '0;
    end else if (!stall_m) begin
      mem_wb_regwrite   <= regwrite_m;
      mem_wb_result_src <= result_src_m;
      mem_wb_alu_result <= alu_result_m;
      mem_wb_read_data  <= load_data;
      mem_wb_pc_plus_4  <= pc_plus_4_m;
      mem_wb_rd         <= rd_m;
    end
  end

  // Writeback result mux.
  always_comb begin
    result_w = '0;
    case (mem_wb_result_src)
      RES_ALU: result_w = mem_wb_alu_result;
      RES_MEM: result_w = mem_wb_read_data;
      RES_PC4: result_w = mem_wb_pc_plus_4;
      default: result_w = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB state,
// a monitor pops and compares one cycle after each issued transaction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_m;
  logic        regwrite_m;
  logic [1:0]  result_src_m;
  logic        memwrite_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] writedata_m;
  logic [31:0] pc_plus_4_m;
  logic [4:0]  rd_m;
  logic        misaligned_m;
  logic        mem_wb_regwrite;
  logic [1:0]  mem_wb_result_src;
  logic [31:0] mem_wb_alu_result;
  logic [31:0] mem_wb_read_data;
  logic [31:0] mem_wb_pc_plus_4;
  logic [4:0]  mem_wb_rd;
  logic [31:0] result_w;

  mem_stage #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .stall_m(stall_m), .regwrite_m(regwrite_m),
    .result_src_m(result_src_m), .memwrite_m(memwrite_m), .funct3_m(funct3_m),
    .alu_result_m(alu_result_m), .writedata_m(writedata_m),
    .pc_plus_4_m(pc_plus_4_m), .rd_m(rd_m), .misaligned_m(misaligned_m),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_result_src(mem_wb_result_src),
    .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_read_data(mem_wb_read_data),
    .mem_wb_pc_plus_4(mem_wb_pc_plus_4), .mem_wb_rd(mem_wb_rd), .result_w(result_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  // Drive one EX/MEM transaction, check misalignment, push expected MEM/WB state.
  task automatic issue(input string n, input logic rst, input logic stl,
                       input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic [4:0] rd, input logic [31:0] exp_rdata,
                       input logic exp_mis);
    exp_t e;
    @(negedge clk);
    reset = rst; stall_m = stl; regwrite_m = rw; result_src_m = rs;
    memwrite_m = mw; funct3_m = f3; alu_result_m = addr; writedata_m = wd;
    pc_plus_4_m = pc; rd_m = rd;
    #1;
    chk({n, ".mis"}, {31'b0, misaligned_m}, {31'b0, exp_mis});
    if (rst) begin
      e = '{name: n, rw: 1'b0, rs: 2'b00, alu: 32'h0, rdata: 32'h0,
            pc: 32'h0, rd: 5'd0, res: 32'h0};
    end else if (stl) begin
      e = last;
      e.name = n;
    end else begin
      e = '{name: n, rw: rw, rs: rs, alu: addr, rdata: exp_rdata,
            pc: pc, rd: rd, res: 32'h0};
      case (rs)
        2'b00:   e.res = addr;
        2'b01:   e.res = exp_rdata;
        2'b10:   e.res = pc;
        default: e.res = 32'h0;
      endcase
    end
    last = e;
    sb.push_back(e);
  endtask

  // Monitor: compare MEM/WB outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".regwrite"},   {31'b0, mem_wb_regwrite}, {31'b0, e.rw});
        chk({e.name, ".result_src"}, {30'b0, mem_wb_result_src}, {30'b0, e.rs});
        chk({e.name, ".alu"},        mem_wb_alu_result, e.alu);
        chk({e.name, ".read_data"},  mem_wb_read_data, e.rdata);
        chk({e.name, ".pc4"},        mem_wb_pc_plus_4, e.pc);
        chk({e.name, ".rd"},         {27'b0, mem_wb_rd}, {27'b0, e.rd});
        chk({e.name, ".result_w"},   result_w, e.res);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; stall_m = 1'b0; regwrite_m = 1'b0; result_src_m = 2'b00;
    memwrite_m = 1'b0; funct3_m = 3'b000; alu_result_m = '0; writedata_m = '0;
    pc_plus_4_m = '0; rd_m = '0;

    //     name         rst  stl  rw   rs     mw   f3      addr          wd            pc        rd  exp_rdata     mis
    issue("reset",      1,   0,   1,   2'b10, 0,   3'b010, 32'h0000_0040, 32'h0,       32'h44,   5,  32'h0,        0);
    // word store then load
    issue("sw_dead",    0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_0010, 32'hDEADBEEF,32'h100,  0,  32'h0,        0);
    issue("lw_dead",    0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0010, 32'h0,       32'h104,  7,  32'hDEADBEEF, 0);
    // byte store over a zeroed word
    issue("sw_zero10",  0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_0010, 32'h0,       32'h108,  0,  32'h0,        0);
    issue("sb_80",      0,   0,   0,   2'b00, 1,   3'b000, 32'h0000_0013, 32'h1234_5680,32'h10C, 0,  32'h0,        0);
    issue("lb_13",      0,   0,   1,   2'b01, 0,   3'b000, 32'h0000_0013, 32'h0,       32'h110,  1,  32'hFFFFFF80, 0);
    issue("lbu_13",     0,   0,   1,   2'b01, 0,   3'b100, 32'h0000_0013, 32'h0,       32'h114,  2,  32'h00000080, 0);
    issue("lw_10",      0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0010, 32'h0,       32'h118,  3,  32'h80000000, 0);
    // half stores, sign/zero extension, misalignment
    issue("sw_zero20",  0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_0020, 32'h0,       32'h11C,  0,  32'h0,        0);
    issue("sh_abcd",    0,   0,   0,   2'b00, 1,   3'b001, 32'h0000_0022, 32'h5555_ABCD,32'h120, 0,  32'h0,        0);
    issue("lh_22",      0,   0,   1,   2'b01, 0,   3'b001, 32'h0000_0022, 32'h0,       32'h124,  4,  32'hFFFFABCD, 0);
    issue("lhu_22",     0,   0,   1,   2'b01, 0,   3'b101, 32'h0000_0022, 32'h0,       32'h128,  5,  32'h0000ABCD, 0);
    issue("sh_mis21",   0,   0,   0,   2'b00, 1,   3'b001, 32'h0000_0021, 32'h0000_1234,32'h12C, 0,  32'h0,        1);
    issue("lw_20",      0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0020, 32'h0,       32'h130,  6,  32'hABCD0000, 0);
    issue("lw_mis21",   0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0021, 32'h0,       32'h134,  8,  32'h0,        1);
    issue("lh_20",      0,   0,   1,   2'b01, 0,   3'b001, 32'h0000_0020, 32'h0,       32'h138,  9,  32'h0,        0);
    issue("ld_bad_f3",  0,   0,   1,   2'b01, 0,   3'b011, 32'h0000_0022, 32'h0,       32'h13C,  9,  32'h0,        0);
    issue("alu_mis_ok", 0,   0,   1,   2'b00, 0,   3'b010, 32'h0000_0023, 32'h0,       32'h140, 10,  32'h0,        0);
    // address wrap
    issue("sw_wrap",    0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_1010, 32'h12345678,32'h144,  0,  32'h0,        0);
    issue("lw_wrap",    0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0010, 32'h0,       32'h148, 11,  32'h12345678, 0);
    // writeback mux selections
    issue("res_pc4",    0,   0,   1,   2'b10, 0,   3'b000, 32'h0000_0777, 32'h0,       32'h104, 31,  32'h0,        0);
    issue("res_zero",   0,   0,   1,   2'b11, 0,   3'b000, 32'h0000_0777, 32'h0,       32'h200, 12,  32'h0,        0);
    // stall holds state and blocks the store
    issue("sw_1111",    0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_0030, 32'h11111111,32'h204,  0,  32'h0,        0);
    issue("sw_stall1",  0,   1,   0,   2'b00, 1,   3'b010, 32'h0000_0030, 32'hCAFEF00D,32'h208,  0,  32'h0,        0);
    issue("sw_stall2",  0,   1,   0,   2'b00, 1,   3'b010, 32'h0000_0030, 32'hCAFEF00D,32'h208,  0,  32'h0,        0);
    issue("lw_30_old",  0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0030, 32'h0,       32'h20C, 13,  32'h11111111, 0);
    issue("sw_cafe",    0,   0,   0,   2'b00, 1,   3'b010, 32'h0000_0030, 32'hCAFEF00D,32'h208,  0,  32'h0,        0);
    issue("lw_30_new",  0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0030, 32'h0,       32'h210, 14,  32'hCAFEF00D, 0);
    // reset mid-store: no write, registers cleared even under stall
    issue("rst_store",  1,   1,   1,   2'b01, 1,   3'b010, 32'h0000_0030, 32'h55555555,32'h214, 15,  32'h0,        0);
    issue("lw_30_post", 0,   0,   1,   2'b01, 0,   3'b010, 32'h0000_0030, 32'h0,       32'h218, 16,  32'hCAFEF00D, 0);

    @(negedge clk);
    memwrite_m = 1'b0; stall_m = 1'b1;
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Sits directly downstream of the execute stage and consumes its EX/MEM register outputs: ALU result, store data, rd, PC+4 and control bits.
- Performs loads and stores against an internal word-organised data RAM, with byte, half and word access plus sign/zero extension.
- Registers results into the MEM/WB pipeline register and drives the writeback result mux.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in data RAM; must be a power of two
- ADDR_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden)

Ports:
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  synchronous, active-high
- stall_m  input  1  hold MEM/WB register, suppress store
- regwrite_m  input  1  EX/MEM regwrite
- result_src_m  input  2  EX/MEM result select
- memwrite_m  input  1  EX/MEM store enable
- funct3_m  input  3  access width/sign code
- alu_result_m  input  32  byte address / ALU result
- writedata_m  input  32  store data (rs2)
- pc_plus_4_m  input  32  PC+4
- rd_m  input  5  destination register
- misaligned_m  output  1  combinational, current access misaligned
- mem_wb_regwrite  output  1  registered
- mem_wb_result_src  output  2  registered
- mem_wb_alu_result  output  32  registered
- mem_wb_read_data  output  32  registered, extended load data
- mem_wb_pc_plus_4  output  32  registered
- mem_wb_rd  output  5  registered
- result_w  output  32  combinational writeback value

Behaviour:
Reset and stall
- Synchronous reset: all mem_wb_* registers go to 0 at the reset edge, so result_w = 0.
- Store is suppressed in any cycle where reset is high.
- RAM contents are not reset.
- stall_m high (reset low): all mem_wb_* registers hold their values and no store occurs.
- Reset takes priority over stall.

Addressing
- Word index = alu_result_m[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Lane = alu_result_m[1:0].

Alignment (access is checked only when memwrite_m=1 or result_src_m=01)
- Byte (funct3 000/100): always aligned.
- Half (001/101): misaligned if lane[0]=1.
- Word (010): misaligned if lane≠0.
- Any other funct3: not misaligned.

Stores (memwrite_m=1, not stalled, not reset, not misaligned; written at rising edge)
- 000 SB: writedata_m[7:0] into byte lane; other bytes unchanged.
- 001 SH: writedata_m[15:0] into half lane[1]; other half unchanged.
- 010 SW: full word written.
- Other funct3: no write.
- Misaligned store: no write; misaligned_m=1 for that cycle.

Loads (result_src_m=01)
- RAM read is combinational; the selected byte/half/word is extended and registered into mem_wb_read_data.
- 000 LB: sign-extend byte at lane.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU, 101 LHU: zero-extend.
- Other funct3, or misaligned: mem_wb_read_data <= 0.
- When result_src_m≠01: mem_wb_read_data <= 0.

Timing and ordering
- Latency: one cycle from EX/MEM inputs to mem_wb_* outputs.
- Store then load to the same word in the next cycle returns the new data (write at edge N, combinational read in cycle N+1).
- Simultaneous memwrite_m=1 and result_src_m=01 is illegal from decode. If it occurs, the store proceeds and load data reflects the pre-write contents.

Registered pass-through (when not stalled)
- mem_wb_regwrite <= regwrite_m
- mem_wb_result_src <= result_src_m
- mem_wb_alu_result <= alu_result_m
- mem_wb_pc_plus_4 <= pc_plus_4_m
- mem_wb_rd <= rd_m
- regwrite is not gated by misalignment; trap handling is outside this block.

Writeback mux (result_w, combinational on mem_wb_result_src)
- 00 → mem_wb_alu_result
- 01 → mem_wb_read_data
- 10 → mem_wb_pc_plus_4
- 11 → 0

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> mem_wb_read_data=0xDEADBEEF and result_w=0xDEADBEEF one cycle after the load.
- SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
- SH 0xABCD @0x22, then LH @0x22 -> 0xFFFFABCD; LHU -> 0x0000ABCD; SH @0x21 -> misaligned_m=1 and word 0x20 unchanged.
- SW at address DEPTH_WORDS*4+0x10 -> LW @0x10 returns the stored value (wrap). result_src=10 with pc_plus_4_m=0x104 -> result_w=0x104.
- stall_m=1 for 2 cycles with SW pending -> mem_wb_* hold and no write; after release, one write occurs.
- Reset asserted mid-store -> no write, all mem_wb_* = 0 next cycle, result_w = 0.
